// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: shared core definitions (NOP constants, stage states, default widths)
package id_ex_pipe_reg_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ALUSEL_W_DEF = 3;
    localparam int ALUOP_W_DEF  = 8;
    localparam int CNT_W_DEF    = 16;
    localparam logic [31:0] ZeroWord       = 32'h0;
    localparam logic [4:0]  NOPRegAddr     = 5'h0;
    localparam logic        WriteDisable   = 1'b0;
    localparam logic [7:0]  EXE_OP_NOP     = 8'h0;
    localparam logic [2:0]  EXE_RESULT_NOP = 3'h0;
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;
endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// pipe_sat_counter: saturating up-counter with asynchronous active-low reset
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with valid/ready, flush and stall counter.
// Define SKID_EN_EN for a 2-entry skid buffer with a registered in_ready.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ALUSEL_W = ALUSEL_W_DEF,
    parameter int ALUOP_W  = ALUOP_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_reg1,
    input  logic [DATA_W-1:0]   in_reg2,
    input  logic [ADDR_W-1:0]   in_waddr,
    input  logic                in_we,
    input  logic [ALUSEL_W-1:0] in_alusel,
    input  logic [ALUOP_W-1:0]  in_aluop,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_reg1,
    output logic [DATA_W-1:0]   out_reg2,
    output logic [ADDR_W-1:0]   out_waddr,
    output logic                out_we,
    output logic [ALUSEL_W-1:0] out_alusel,
    output logic [ALUOP_W-1:0]  out_aluop,
    output logic [CNT_W-1:0]    stall_cnt
);
    localparam int PW = 2 * DATA_W + ADDR_W + 1 + ALUSEL_W + ALUOP_W;
    localparam logic [PW-1:0] NOP = {DATA_W'(ZeroWord), DATA_W'(ZeroWord), ADDR_W'(NOPRegAddr),
                                     WriteDisable, ALUSEL_W'(EXE_RESULT_NOP), ALUOP_W'(EXE_OP_NOP)};

    state_e        state_q, state_d;
    logic [PW-1:0] in_bus, main_q, main_d;
    logic          rdy_q, rdy_d, tin, tout;

    assign in_bus = {in_reg1, in_reg2, in_waddr, in_we, in_alusel, in_aluop};
    assign tin    = in_valid & in_ready;
    assign tout   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= NOP;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            rdy_q   <= rdy_d;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = tin ? FULL : EMPTY;
`ifdef SKID_EN_EN
            FULL:    state_d = (tout && !tin) ? EMPTY : (!tout && tin) ? SKID : FULL;
            SKID:    state_d = tout ? FULL : SKID;
`else
            FULL:    state_d = (tout && !tin) ? EMPTY : FULL;
`endif
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

`ifdef SKID_EN_EN
    logic [PW-1:0] skid_q, skid_d;
    always_ff @(posedge clk or negedge rst)
        if (!rst) skid_q <= NOP;
        else skid_q <= skid_d;
    // in_ready is registered: it already reflects whether next cycle has room
    assign rdy_d    = state_d != SKID;
    assign in_ready = rdy_q;
`else
    assign rdy_d    = 1'b1;
    assign in_ready = rdy_q & (!out_valid | out_ready);
`endif

    always_comb begin
        main_d = main_q;
`ifdef SKID_EN_EN
        skid_d = skid_q;
`endif
        if (flush) begin
            main_d = NOP;
`ifdef SKID_EN_EN
            skid_d = NOP;
`endif
        end else begin
            if (tin && (state_q == EMPTY || tout)) main_d = in_bus;
`ifdef SKID_EN_EN
            else if (tout) main_d = (state_q == SKID) ? skid_q : NOP;
            if (tin && !tout && state_q == FULL) skid_d = in_bus;
            if (tout && state_q == SKID) skid_d = NOP;
`else
            else if (tout) main_d = NOP;
`endif
        end
    end

    always_comb begin
        out_valid = state_q != EMPTY;
        {out_reg1, out_reg2, out_waddr, out_we, out_alusel, out_aluop} = main_q;
    end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(out_valid & ~out_ready),
        .cnt(stall_cnt)
    );
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed self-checking bench for id_ex_pipe_reg (default widths)
module tb_id_ex_pipe_reg;
    logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_reg1 = '0, in_reg2 = '0, out_reg1, out_reg2;
    logic [4:0]  in_waddr = '0, out_waddr;
    logic        in_we = 1'b0, out_we;
    logic [2:0]  in_alusel = '0, out_alusel;
    logic [7:0]  in_aluop = '0, out_aluop;
    logic [15:0] stall_cnt;
    int checks = 0, failures = 0;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg1(in_reg1), .in_reg2(in_reg2), .in_waddr(in_waddr), .in_we(in_we),
        .in_alusel(in_alusel), .in_aluop(in_aluop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg1(out_reg1), .out_reg2(out_reg2), .out_waddr(out_waddr), .out_we(out_we),
        .out_alusel(out_alusel), .out_aluop(out_aluop),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r1, input logic [7:0] op);
        in_valid  = v;
        in_reg1   = r1;
        in_reg2   = r1 ^ 32'hFFFF_0000;
        in_waddr  = r1[4:0];
        in_we     = 1'b1;
        in_alusel = r1[2:0];
        in_aluop  = op;
    endtask

    initial begin
        // held in reset with a beat already offered
        drive(1'b1, 32'h11, 8'h21);
        in_waddr  = 5'd3;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_aluop", out_aluop, 0);
        #10 rst = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);
        check("rel_no_capture", out_valid, 0);
        tick();
        check("first_valid", out_valid, 1);
        check("first_reg1", out_reg1, 32'h11);
        check("first_waddr", out_waddr, 3);
        check("first_reg2", out_reg2, 32'hFFFF_0011);
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_nop_reg1", out_reg1, 0);

        // back-to-back stream of 8 beats
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + i, 8'h40 + 8'(i));
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_reg1", out_reg1, 32'h100 + i);
            check("stream_aluop", out_aluop, 8'h40 + i);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end", out_valid, 0);
        check("stream_stall", stall_cnt, 0);

`ifdef SKID_EN_EN
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 8'h0A);
        tick();
        check("skid_a_out", out_reg1, 32'hA);
        check("skid_rdy_full", in_ready, 1);
        drive(1'b1, 32'hB, 8'h0B);
        tick();
        check("skid_hold_a", out_reg1, 32'hA);
        check("skid_rdy_low", in_ready, 0);
        in_valid = 1'b0;
        tick();
        check("skid_stable_a", out_reg1, 32'hA);
        check("skid_stall2", stall_cnt, 2);
        out_ready = 1'b1;
        tick();
        check("skid_b_out", out_reg1, 32'hB);
        check("skid_b_valid", out_valid, 1);
        check("skid_rdy_back", in_ready, 1);
        tick();
        check("skid_empty", out_valid, 0);
        out_ready = 1'b0;
        drive(1'b1, 32'hC, 8'h0C);
        tick();
        drive(1'b1, 32'hD, 8'h0D);
        tick();
        check("pre_flush_rdy", in_ready, 0);
        drive(1'b1, 32'hE, 8'h0E);
        flush = 1'b1;
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_aluop", out_aluop, 0);
        check("flush_we", out_we, 0);
        check("flush_stall_kept", stall_cnt, 4);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("flush_dropped", out_valid, 0);
        check("flush_rdy", in_ready, 1);
`else
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 8'h0A);
        tick();
        check("bp_a_out", out_reg1, 32'hA);
        check("bp_rdy_low", in_ready, 0);
        drive(1'b1, 32'hB, 8'h0B);
        tick();
        check("bp_hold_a", out_reg1, 32'hA);
        check("bp_stall1", stall_cnt, 1);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_comb", in_ready, 1);
        flush = 1'b1;
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_aluop", out_aluop, 0);
        check("flush_we", out_we, 0);
        check("flush_stall_kept", stall_cnt, 1);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush_dropped", out_valid, 0);
`endif

        // saturation of the stall counter
        out_ready = 1'b0;
        drive(1'b1, 32'hF0, 8'hF0);
        tick();
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_max", stall_cnt, 16'hFFFF);
        check("sat_payload", out_reg1, 32'hF0);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold", stall_cnt, 16'hFFFF);

        // asynchronous reset between edges
        out_ready = 1'b1;
        drive(1'b1, 32'h77, 8'h77);
        tick();
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_reg1", out_reg1, 0);
        check("arst_aluop", out_aluop, 0);
        check("arst_stall", stall_cnt, 0);
        check("arst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID→EX pipeline register for the in-order integer core. It carries decoded operands, the writeback target and the ALU selector/opcode from decode to execute. It adds a valid/ready handshake, synchronous flush, bubble insertion, a saturating back-pressure counter and an optional skid buffer that registers the upstream ready path. It replaces the fixed-width, always-advancing ID/EX register between the decode and execute stages.

## Interface
- DATA_W, 32, width of reg1/reg2 operands
- ADDR_W, 5, register-file address width
- ALUSEL_W, 3, ALU result-select width
- ALUOP_W, 8, ALU opcode width
- CNT_W, 16, back-pressure counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous kill of all held entries (branch/exception redirect)
- in_valid  in  1  decode presents a beat
- in_ready  out  1  stage can accept a beat
- in_reg1, in_reg2  in  DATA_W  operands
- in_waddr  in  ADDR_W  destination register
- in_we  in  1  writeback enable
- in_alusel  in  ALUSEL_W  result select
- in_aluop  in  ALUOP_W  opcode
- out_valid  out  1  execute beat valid
- out_ready  in  1  execute accepts beat
- out_reg1, out_reg2, out_waddr, out_we, out_alusel, out_aluop  out  same widths  registered payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

## Operation
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- Payload outputs are always registered. When out_valid=0 they show the NOP bubble: zero operands, waddr=NOP address (0), we=disabled, alusel=RESULT_NOP, aluop=OP_NOP.
- States:
  - EMPTY: no beat held.
  - FULL: main register holds a beat.
  - SKID: main and skid both hold a beat. SKID exists only with SKID_EN.
- Transitions when flush=0:
  - EMPTY + in → FULL.
  - FULL + out + in → FULL, main loaded with the new beat.
  - FULL + out, no in → EMPTY.
  - FULL + in, no out → SKID, beat goes to skid. Without SKID_EN this case cannot occur.
  - SKID + out → FULL, main loaded from skid.
- flush=1: next state EMPTY; payload returns to NOP values; a beat transferred in that cycle is discarded. Flush has priority over every transition.
- stall_cnt: increments when out_valid & !out_ready, holds at all-ones, never clears except on reset. Flush does not clear it.
- Reset (rst=0, asynchronous):
  - state EMPTY, payload outputs NOP, out_valid=0, stall_cnt=0.
  - in_ready=0 while rst=0, and 1 from the first edge after release.

## Timing
- Latency: 1 cycle from transfer in to out_valid.
- Throughput: 1 beat/cycle with out_ready held high.
- out_valid and payload depend only on flops.
- With SKID_EN, in_ready is a flop (=1 in EMPTY/FULL, 0 in SKID) and has no combinational path from out_ready or flush.
- Without SKID_EN, in_ready = !out_valid | out_ready, which is combinational.
- Once out_valid=1, payload and out_valid must stay stable until transfer out or flush.
- Order is preserved: the skid beat always exits after the main beat.

## Configuration
- SKID_EN_EN defined:
  - 2-entry storage and registered in_ready.
  - Decode sees back-pressure one cycle late, with zero beat loss.
- SKID_EN_EN undefined:
  - Single register and combinational in_ready.
  - The SKID state and skid flops are removed; all other behaviour is identical.

## Structure
- The shared core definitions package holds:
  - NOP constants: ZeroWord, NOPRegAddr, WriteDisable, EXE_OP_NOP, EXE_RESULT_NOP.
  - The state encoding EMPTY/FULL/SKID.
  - The default widths.
- One sub-module, pipe_sat_counter (CNT_W, inc, async active-low reset), is used for stall_cnt.
- Payload packing into one bus is internal to this block.

## Test plan
- Reset release, in_valid=1, reg1=0x11, waddr=3, out_ready=1 → out_valid=1 next cycle, out_reg1=0x11, out_waddr=3; in_ready=0 during reset.
- Stream of 8 beats with out_ready=1 → 8 outputs in order on consecutive cycles, no bubbles.
- SKID_EN_EN: out_ready=0 while beats A,B are offered → A held at the output, B captured, in_ready=0 after B. out_ready=1 → A then B, then in_ready=1.
- flush asserted in the SKID state with an in beat offered → next cycle out_valid=0, payload NOP (aluop=OP_NOP, we=0), beat dropped.
- out_ready=0 for 70000 cycles with CNT_W=16 → stall_cnt=0xFFFF, held.
- rst asserted mid-stream between clock edges → outputs go NOP and stall_cnt=0 immediately, without waiting for a clock edge.
